// File: rtl/lab61soc_key_pio_in.sv
// -----------------------------------------------------------------------------
// lab61soc_key_pio_in
//
// Avalon-MM input PIO for push-buttons / status lines, with per-bit edge
// capture and a level interrupt.
//
// Register map (read latency 1, unused upper bits read as zero):
//   addr 0  DATA     RO   filtered input value
//   addr 1  EDGESEL  RW   per bit: 0 = capture rising edge, 1 = falling edge
//   addr 2  IRQMASK  RW   per bit interrupt enable
//   addr 3  EDGECAP  R/W1C captured edges; an edge arriving in the same
//                        cycle as a clear keeps the bit set
//
// Ports:
//   clk         system clock, all state on rising edge
//   reset_n     asynchronous active-low reset
//   address     register select
//   chipselect  slave select
//   write_n     active-low write strobe (qualified by chipselect)
//   writedata   write data, only [WIDTH-1:0] is used
//   in_port     asynchronous external inputs
//   readdata    registered read data
//   irq         level interrupt, OR of (EDGECAP & IRQMASK), registered
//
// Optional feature: define KEY_PIO_DEBOUNCE_EN to insert a per-bit debounce
// filter (DEBOUNCE_CYCLES consecutive mismatching samples flip the filtered
// value). Without the macro the filtered value is the synchronizer output
// and DEBOUNCE_CYCLES has no effect.
// -----------------------------------------------------------------------------
module lab61soc_key_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Zero-extend a WIDTH-bit register value onto the 32-bit read bus.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // Synchronizer stages.
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync_q;

    // Filtered value and its one-cycle-delayed copy.
    logic [WIDTH-1:0] filt_s;
    logic [WIDTH-1:0] prev_filt_q;

    // Software-visible registers.
    logic [WIDTH-1:0] edgesel_q, edgesel_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             wr_en_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;

    // Only the low WIDTH bits of writedata carry register content.
    logic unused_wdata_s;
    assign unused_wdata_s = ^writedata;

    // Two-flop synchronizer for the asynchronous inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= in_port;
            sync_q  <= sync1_q;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    // Per-bit debounce: a bit only changes after DEBOUNCE_CYCLES consecutive
    // samples that disagree with the current filtered value.
    logic [WIDTH-1:0]       filt_q, filt_d;
    logic [WIDTH-1:0][15:0] cnt_q, cnt_d;

    // Debounce counter and filtered-value next state.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_q[i] != filt_q[i]) begin
                if (cnt_q[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i] = sync_q[i];
                    cnt_d[i]  = 16'd0;
                end else begin
                    cnt_d[i]  = cnt_q[i] + 16'd1;
                end
            end else begin
                // Any return to agreement discards the partial count.
                cnt_d[i] = 16'd0;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_s = filt_q;
`else
    assign filt_s = sync_q;
`endif

    // Bus decode, edge detection and register next-state logic.
    always_comb begin
        wr_en_s    = chipselect & ~write_n;
        wdata_s    = writedata[WIDTH-1:0];
        edgesel_d  = edgesel_q;
        irqmask_d  = irqmask_q;
        clr_s      = '0;
        readdata_d = 32'd0;

        // Edge polarity uses the currently stored EDGESEL, so a new selection
        // takes effect from the cycle after it is written.
        edge_s = (~edgesel_q & filt_s & ~prev_filt_q) |
                 ( edgesel_q & ~filt_s & prev_filt_q);

        if (wr_en_s) begin
            case (address)
                2'd0:    begin end
                2'd1:    edgesel_d = wdata_s;
                2'd2:    irqmask_d = wdata_s;
                2'd3:    clr_s     = wdata_s;
                default: begin end
            endcase
        end else begin
            clr_s = '0;
        end

        // Set dominates clear so an edge coinciding with a clear is not lost.
        edgecap_d = (edgecap_q & ~clr_s) | edge_s;

        // irq is computed from next-state register values so it rises in the
        // same cycle EDGECAP does, while still being a flop output.
        irq_d = |(edgecap_d & irqmask_d);

        // DATA reads the registered filtered value so it lines up with
        // EDGECAP: both become visible on readdata together.
        case (address)
            2'd0:    readdata_d = zext(prev_filt_q);
            2'd1:    readdata_d = zext(edgesel_q);
            2'd2:    readdata_d = zext(irqmask_q);
            2'd3:    readdata_d = zext(edgecap_q);
            default: readdata_d = 32'd0;
        endcase
    end

    // Register bank, edge history and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_filt_q <= '0;
            edgesel_q   <= '0;
            irqmask_q   <= '0;
            edgecap_q   <= '0;
            readdata_q  <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            prev_filt_q <= filt_s;
            edgesel_q   <= edgesel_d;
            irqmask_q   <= irqmask_d;
            edgecap_q   <= edgecap_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_lab61soc_key_pio_in.sv
module tb_lab61soc_key_pio_in;

    localparam int WIDTH = 4;
    localparam int DEB   = 16;
`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int SETTLE = DEB + 8;
`else
    localparam int SETTLE = 5;
`endif

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    lab61soc_key_pio_in #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          is_irq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] exp, input bit is_irq);
        exp_t e;
        e.tag    = tag;
        e.exp    = exp;
        e.is_irq = is_irq;
        sb.push_back(e);
    endtask

    task automatic check_next();
        exp_t        e;
        logic [31:0] obs;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=empty expected=entry");
        end else begin
            e   = sb.pop_front();
            obs = e.is_irq ? {31'd0, irq} : readdata;
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        push(tag, exp, 1'b0);
        cycles(1);
        check_next();
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        push(tag, {31'd0, exp}, 1'b1);
        check_next();
    endtask

    task automatic chk_rd_now(input logic [31:0] exp, input string tag);
        push(tag, exp, 1'b0);
        check_next();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        in_port    = 4'h0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'd0;

        // Reset state
        #12;
        chk_irq(1'b0, "reset_irq");
        chk_rd_now(32'd0, "reset_readdata");
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd0, 32'd0, "reset_data");
        rd(2'd1, 32'd0, "reset_edgesel");
        rd(2'd2, 32'd0, "reset_irqmask");
        rd(2'd3, 32'd0, "reset_edgecap");
        chk_irq(1'b0, "reset_irq_after");

        // Rising edge on bit 0 with mask 1
        wr(2'd2, 32'h1);
        wr(2'd1, 32'h0);
        address = 2'd0;
        in_port = 4'b0001;
`ifndef KEY_PIO_DEBOUNCE_EN
        push("lat_irq_c1", 32'd0, 1'b1); push("lat_data_c1", 32'd0, 1'b0);
        cycles(1); check_next(); check_next();
        push("lat_irq_c2", 32'd0, 1'b1); push("lat_data_c2", 32'd0, 1'b0);
        cycles(1); check_next(); check_next();
        push("lat_irq_c3", 32'd1, 1'b1); push("lat_data_c3", 32'd0, 1'b0);
        cycles(1); check_next(); check_next();
        push("lat_data_c4", 32'd1, 1'b0);
        cycles(1); check_next();
`else
        cycles(SETTLE);
        chk_irq(1'b1, "deb_irq_b0");
        rd(2'd0, 32'd1, "deb_data_b0");
`endif
        rd(2'd3, 32'h1, "edgecap_b0");
        wr(2'd3, 32'h1);
        chk_irq(1'b0, "irq_clear_b0");
        rd(2'd3, 32'h0, "edgecap_cleared_b0");

        // Falling-edge selection on bit 1, masked
        wr(2'd2, 32'h0);
        wr(2'd1, 32'h2);
        in_port = 4'b0011;
        cycles(SETTLE);
        rd(2'd3, 32'h0, "no_cap_rise_b1");
        in_port = 4'b0001;
        cycles(SETTLE);
        rd(2'd3, 32'h2, "cap_fall_b1");
        chk_irq(1'b0, "masked_irq_1");
        in_port = 4'b0011;
        cycles(SETTLE);
        rd(2'd3, 32'h2, "cap_hold_b1");
        chk_irq(1'b0, "masked_irq_2");
        rd(2'd1, 32'h2, "edgesel_rb");
        rd(2'd2, 32'h0, "irqmask_rb");
        rd(2'd0, 32'h3, "data_0011");
        wr(2'd2, 32'h2);
        chk_irq(1'b1, "unmask_irq");

        // Clear coinciding with a new edge on the same bit
        in_port = 4'b0001;
`ifndef KEY_PIO_DEBOUNCE_EN
        cycles(2);
        wr(2'd3, 32'h2);
        chk_irq(1'b1, "set_wins_irq");
        rd(2'd3, 32'h2, "set_wins_cap");
`else
        cycles(SETTLE);
`endif
        wr(2'd3, 32'h2);
        chk_irq(1'b0, "clear_irq_b1");
        rd(2'd3, 32'h0, "clear_cap_b1");

        // Capture all bits, then reset asynchronously mid-operation
        wr(2'd1, 32'h0);
        in_port = 4'b0000;
        cycles(SETTLE);
        rd(2'd3, 32'h0, "no_cap_fall_all");
        in_port = 4'b1111;
        cycles(SETTLE);
        rd(2'd3, 32'hF, "cap_all");
        wr(2'd2, 32'hF);
        chk_irq(1'b1, "irq_all");
        address = 2'd3;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_irq(1'b0, "async_reset_irq");
        chk_rd_now(32'd0, "async_reset_readdata");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd2, 32'h0, "post_reset_irqmask");
        rd(2'd1, 32'h0, "post_reset_edgesel");
        cycles(SETTLE);
        rd(2'd3, 32'hF, "rise_after_reset");
        rd(2'd0, 32'hF, "data_after_reset");
        chk_irq(1'b0, "irq_after_reset");

`ifdef KEY_PIO_DEBOUNCE_EN
        // Glitch rejection and stable acceptance on bit 2
        in_port = 4'b1011;
        cycles(SETTLE);
        wr(2'd3, 32'hF);
        rd(2'd3, 32'h0, "deb_cap_clear");
        rd(2'd0, 32'hB, "deb_data_base");
        in_port = 4'b1111;
        cycles(10);
        in_port = 4'b1011;
        cycles(SETTLE);
        rd(2'd0, 32'hB, "deb_glitch_data");
        rd(2'd3, 32'h0, "deb_glitch_cap");
        in_port = 4'b1111;
        cycles(20);
        rd(2'd0, 32'hF, "deb_stable_data");
        rd(2'd3, 32'h4, "deb_stable_cap");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab61soc_key_pio_in.md
LAB61SOC_KEY_PIO_IN -- requirements
Module: lab61soc_key_pio_in

Interface
REQ-001 Parameter WIDTH, default 4: number of input bits sampled (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: stable-sample count required by the debounce filter (2..65535).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  2  Avalon-MM slave register select.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe, valid with chipselect.
REQ-008 writedata  input  32  write data.
REQ-009 in_port  input  WIDTH  asynchronous external inputs (keys / USB status lines).
REQ-010 readdata  output  32  registered read data.
REQ-011 irq  output  1  level interrupt request, active-high.

Function
REQ-012 Map: addr 0 DATA (RO, filtered input); addr 1 EDGESEL (RW, per bit 0=rising, 1=falling); addr 2 IRQMASK (RW); addr 3 EDGECAP (R, write-1-to-clear).
REQ-013 Write occurs when chipselect=1, write_n=0; only writedata[WIDTH-1:0] used; writes to addr 0 ignored.
REQ-014 Each in_port bit passes a 2-flop synchronizer; sync output is sync_q.
REQ-015 Filtered value filt equals sync_q when macro absent, debounced value when present (REQ-027).
REQ-016 prev_filt register holds filt from the previous cycle; edge[i] = rising: filt&~prev_filt, falling: ~filt&prev_filt, per EDGESEL[i].
REQ-017 EDGECAP[i] sets on edge[i]; clears on addr-3 write with writedata[i]=1; simultaneous set and clear -> bit remains 1 (set wins).
REQ-018 EDGECAP bits set by edges regardless of IRQMASK.
REQ-019 irq = OR over i of (EDGECAP[i] & IRQMASK[i]), driven from registers only, no combinational path from in_port or bus inputs.
REQ-020 readdata updated every cycle with zero-extended content of register at address (Avalon read latency 1); bits 31:WIDTH read 0.
REQ-021 Reads have no side effects; EDGECAP not cleared by reads.
REQ-022 Latency, macro absent: in_port change -> DATA visible at readdata 4 cycles later (2 sync, 1 edge/EDGECAP, 1 readdata); EDGECAP set 3 cycles after change; irq same cycle as EDGECAP.
REQ-023 Changing EDGESEL does not retroactively modify EDGECAP; new selection applies from next cycle.

Reset
REQ-024 reset_n low: sync flops, filt, prev_filt, EDGESEL, IRQMASK, EDGECAP, debounce counters, readdata all 0; irq 0.
REQ-025 Reset asserted mid-operation clears all state immediately without waiting for clk.
REQ-026 Input held high through reset release produces a rising edge (filt 0 -> 1) after synchronizer/debounce delay; this is intended.

Configuration
REQ-027 Macro KEY_PIO_DEBOUNCE_EN defined: per-bit counter; if sync_q[i] != filt[i] counter increments, else counter resets to 0; when counter reaches DEBOUNCE_CYCLES-1 with mismatch, filt[i] <= sync_q[i] and counter resets; any return to match before that discards the count.
REQ-028 KEY_PIO_DEBOUNCE_EN undefined: no counters synthesized, filt = sync_q, DEBOUNCE_CYCLES ignored.

Verification
REQ-029 Reset, in_port=0 -> readdata=0 at all four addresses, irq=0.
REQ-030 Macro off, IRQMASK=0x1, EDGESEL=0, in_port[0] 0->1 -> EDGECAP=0x1 and irq=1 exactly 3 cycles after change; write 0x1 to addr 3 -> irq=0 next cycle.
REQ-031 EDGESEL=0x2, in_port[1] 1->0 -> EDGECAP=0x2; in_port[1] 0->1 -> no further set; IRQMASK=0 -> irq stays 0 while EDGECAP=0x2.
REQ-032 Clear write to addr 3 in same cycle as new edge on same bit -> EDGECAP bit reads 1.
REQ-033 Macro on, DEBOUNCE_CYCLES=16: 10-cycle glitch on in_port[2] -> DATA and EDGECAP unchanged; 20-cycle stable high -> DATA[2]=1 and EDGECAP[2]=1.
REQ-034 Assert reset_n low mid-debounce with EDGECAP=0xF -> all registers 0 asynchronously, irq=0 before next clk edge.
